// File: rtl/mem_port_arbiter_if.sv
// Bundle for the memory-port arbiter: fetch and load/store requesters on one
// side, the shared external memory port on the other.
//   slave  : arbiter view (takes requests and mem_ack/mem_rdata, drives the rest)
//   master : environment view (drives requests and memory responses)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (DM);
// one transaction in flight, DM preferred. Ports: clk, rst (async, active-high),
// bus (mem_port_arbiter_if.slave). Optional macro ARB_STARVE_EN lets IF win
// after MAX_DM_STREAK back-to-back DM grants taken while IF was waiting.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef ARB_STARVE_EN
    ,
    parameter int MAX_DM_STREAK = 4
`endif
) (
    input logic                 clk,
    input logic                 rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM
    } state_e;

    state_e            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [BE_W-1:0]   mem_be_q;
    logic              if_rvalid_q;
    logic              dm_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic idle;
    logic force_if;
    logic pick_dm;
    logic pick_if;

    assign idle    = (state_q == IDLE);
    // Grants are combinational so a request is accepted in its first cycle.
    assign pick_dm = idle && bus.dm_req && !force_if;
    assign pick_if = idle && bus.if_req && !pick_dm;

`ifdef ARB_STARVE_EN
    localparam int SW = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    assign force_if = bus.if_req && bus.dm_req &&
                      (streak_q == SW'(MAX_DM_STREAK));

    // Counts DM grants that made a waiting fetch wait longer; saturates.
    always_comb begin
        streak_d = streak_q;
        if (pick_dm) begin
            if (!bus.if_req)
                streak_d = '0;
            else if (streak_q != SW'(MAX_DM_STREAK))
                streak_d = streak_q + 1'b1;
        end else if (pick_if) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            streak_q <= '0;
        else
            streak_q <= streak_d;
    end
`else
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_dm) begin
                        state_q     <= BUSY_DM;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        mem_be_q    <= bus.dm_be;
                    end else if (pick_if) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '1;
                    end
                end
                BUSY_IF: begin
                    if (bus.mem_ack) begin
                        if_rdata_q  <= bus.mem_rdata;
                        if_rvalid_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                BUSY_DM: begin
                    if (bus.mem_ack) begin
                        // Stores complete without disturbing load data.
                        if (!mem_we_q)
                            dm_rdata_q <= bus.mem_rdata;
                        dm_rvalid_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = pick_if;
    assign bus.dm_gnt    = pick_dm;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset abort, fetch, store, contention,
// starvation order (both macro settings) and spurious ack / dropped request.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   passes;
    int   total;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic exp_dm;
        passes = 0;
        total  = 0;
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0;
        bus.dm_wdata = '0; bus.dm_be = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_rvalid", bus.if_rvalid, 0);
        chk("rst_dm_rvalid", bus.dm_rvalid, 0);
        chk("rst_gnts", {bus.if_gnt, bus.dm_gnt}, 0);
        rst = 1'b0;

        // 1: reset while BUSY_DM
        @(negedge clk);
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h80;
        #1 chk("t1_dm_gnt", bus.dm_gnt, 1);
        @(negedge clk);
        bus.dm_req = 0;
        chk("t1_mem_req", bus.mem_req, 1);
        #2 rst = 1'b1;
        #1 chk("t1_async_mem_req", bus.mem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ack = 1; bus.mem_rdata = 32'hAAAA5555;
        @(negedge clk);
        bus.mem_ack = 0;
        chk("t1_no_rvalid", bus.dm_rvalid, 0);
        chk("t1_mem_req_idle", bus.mem_req, 0);
        chk("t1_dm_rdata", bus.dm_rdata, 0);

        // 2: fetch, ack two cycles after mem_req
        bus.if_req = 1; bus.if_addr = 32'h100;
        #1 chk("t2_if_gnt", bus.if_gnt, 1);
        @(negedge clk);
        bus.if_req = 0;
        chk("t2_mem_req", bus.mem_req, 1);
        chk("t2_mem_addr", bus.mem_addr, 32'h100);
        chk("t2_mem_be", bus.mem_be, 4'hF);
        chk("t2_mem_we", bus.mem_we, 0);
        chk("t2_no_gnt_busy", bus.if_gnt, 0);
        @(negedge clk);
        chk("t2_mem_req_wait", bus.mem_req, 1);
        chk("t2_rvalid_early", bus.if_rvalid, 0);
        @(negedge clk);
        bus.mem_ack = 1; bus.mem_rdata = 32'h00500093;
        @(negedge clk);
        bus.mem_ack = 0;
        chk("t2_if_rvalid", bus.if_rvalid, 1);
        chk("t2_if_rdata", bus.if_rdata, 32'h00500093);
        chk("t2_mem_req_clr", bus.mem_req, 0);
        @(negedge clk);
        chk("t2_rvalid_pulse", bus.if_rvalid, 0);
        chk("t2_rdata_hold", bus.if_rdata, 32'h00500093);

        // 3: store, 3-cycle ack wait
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h200;
        bus.dm_wdata = 32'hDEADBEEF; bus.dm_be = 4'b0011;
        #1 chk("t3_dm_gnt", bus.dm_gnt, 1);
        @(negedge clk);
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 32'hFFF;
        bus.dm_wdata = 32'h0; bus.dm_be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            chk("t3_mem_req", bus.mem_req, 1);
            chk("t3_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata,
                              bus.mem_be}, {1'b1, 32'h200, 32'hDEADBEEF, 4'b0011});
            @(negedge clk);
        end
        bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
        @(negedge clk);
        bus.mem_ack = 0;
        chk("t3_dm_rvalid", bus.dm_rvalid, 1);
        chk("t3_dm_rdata_kept", bus.dm_rdata, 0);
        @(negedge clk);
        chk("t3_rvalid_pulse", bus.dm_rvalid, 0);

        // 4: contention, DM first, IF on slot after dm_rvalid
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h300;
        bus.if_req = 1; bus.if_addr = 32'h400;
        #1 chk("t4_gnts", {bus.dm_gnt, bus.if_gnt}, 2'b10);
        @(negedge clk);
        bus.dm_req = 0;
        chk("t4_mem_addr_dm", bus.mem_addr, 32'h300);
        chk("t4_if_wait", bus.if_gnt, 0);
        bus.mem_ack = 1; bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.mem_ack = 0;
        chk("t4_dm_rvalid", bus.dm_rvalid, 1);
        chk("t4_dm_rdata", bus.dm_rdata, 32'hCAFEF00D);
        #1 chk("t4_if_gnt_slot", bus.if_gnt, 1);
        @(negedge clk);
        bus.if_req = 0;
        chk("t4_mem_addr_if", bus.mem_addr, 32'h400);
        bus.mem_ack = 1; bus.mem_rdata = 32'h11112222;
        @(negedge clk);
        bus.mem_ack = 0;
        chk("t4_if_rdata", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h11112222});

        // 5: both held high, six grants
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h500;
        bus.if_req = 1; bus.if_addr = 32'h600;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_STARVE_EN
            exp_dm = (i != 4);
`else
            exp_dm = 1'b1;
`endif
            #1 chk("t5_order", {bus.dm_gnt, bus.if_gnt}, {exp_dm, !exp_dm});
            @(negedge clk);
            bus.mem_ack = 1; bus.mem_rdata = 32'h1000 + i;
            @(negedge clk);
            bus.mem_ack = 0;
        end
        bus.dm_req = 0; bus.if_req = 0;
        chk("t5_last_dm_rdata", bus.dm_rdata, 32'h1005);

        // 6: spurious ack in IDLE, request dropped before grant while busy
        @(negedge clk);
        bus.mem_ack = 1; bus.mem_rdata = 32'hBAD;
        @(negedge clk);
        bus.mem_ack = 0;
        chk("t6_spur_rvalid", {bus.if_rvalid, bus.dm_rvalid}, 0);
        chk("t6_spur_mem_req", bus.mem_req, 0);
        chk("t6_spur_dm_rdata", bus.dm_rdata, 32'h1005);
        bus.if_req = 1; bus.if_addr = 32'h700;
        #1 chk("t6_if_gnt", bus.if_gnt, 1);
        @(negedge clk);
        bus.if_req = 0; bus.dm_req = 1; bus.dm_addr = 32'h800;
        #1 chk("t6_no_gnt_busy", bus.dm_gnt, 0);
        @(negedge clk);
        bus.dm_req = 0;
        bus.mem_ack = 1; bus.mem_rdata = 32'h77;
        @(negedge clk);
        bus.mem_ack = 0;
        chk("t6_if_done", {bus.if_rvalid, bus.dm_rvalid, bus.if_rdata},
            {2'b10, 32'h77});
        @(negedge clk);
        chk("t6_dropped", {bus.mem_req, bus.dm_gnt, bus.dm_rvalid}, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
